// File: rtl/soc_run_ctrl.sv
// soc_run_ctrl: SoC reset sequencing, RUN cycle count, mailbox verdict and global timeout.
// Optional heartbeat watchdog is compiled in with SOC_RUN_CTRL_HEARTBEAT_EN.
module soc_run_ctrl #(
    parameter int unsigned RST_CYCLES     = 10,
    parameter int unsigned TIMEOUT_CYCLES = 100000,
    parameter int unsigned HB_CYCLES      = 4096,
    parameter int unsigned CNT_W          = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             restart,
    input  logic             mb_valid,
    input  logic [31:0]      mb_data,
    output logic             mb_ready,
    output logic             soc_rst_n,
    output logic             done,
    output logic             pass,
    output logic             timeout,
    output logic [15:0]      fail_code,
    output logic [CNT_W-1:0] cycle_cnt
);
    typedef enum logic [1:0] {S_RESET, S_RUN, S_DONE} state_t;

    localparam logic [7:0]       RST_LAST = 8'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYCLES);

    if (RST_CYCLES < 1 || RST_CYCLES > 255 || HB_CYCLES < 1 ||
        64'(TIMEOUT_CYCLES) >= (64'd1 << CNT_W)) begin : g_bad_params
        $error("soc_run_ctrl: illegal parameter combination");
    end

    state_t           state_q, state_d;
    logic [7:0]       rst_cnt_q, rst_cnt_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic             pass_q, pass_d, timeout_q, timeout_d;
    logic [15:0]      code_q, code_d;
    logic             soc_rst_n_q, mb_ready_q, done_q;
    logic             xfer, term, hb_hit;

    assign xfer    = mb_valid && mb_ready_q;
    assign term    = xfer && (mb_data[31:16] == 16'hD0DE);
    assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);

`ifdef SOC_RUN_CTRL_HEARTBEAT_EN
    logic [31:0] hb_q, hb_d;
    // Counts RUN cycles since the last accepted word; any accepted word reloads it.
    assign hb_hit = (hb_q + 32'd1) == HB_CYCLES;
    assign hb_d   = (state_q == S_RUN && !xfer) ? hb_q + 32'd1 : 32'd0;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) hb_q <= '0;
        else        hb_q <= hb_d;
`else
    assign hb_hit = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        rst_cnt_d = rst_cnt_q;
        cnt_d     = cnt_q;
        pass_d    = pass_q;
        timeout_d = timeout_q;
        code_d    = code_q;
        case (state_q)
            S_RESET: begin
                rst_cnt_d = (rst_cnt_q == RST_LAST) ? 8'd0 : rst_cnt_q + 8'd1;
                state_d   = (rst_cnt_q == RST_LAST) ? S_RUN : S_RESET;
            end
            S_RUN: begin
                cnt_d = cnt_inc;
                // Precedence: terminate word, then global timeout, then heartbeat.
                if (term) begin
                    state_d   = S_DONE;
                    pass_d    = mb_data[15:0] == 16'h0000;
                    timeout_d = 1'b0;
                    code_d    = mb_data[15:0];
                end else if (cnt_inc == CNT_MAX) begin
                    state_d   = S_DONE;
                    pass_d    = 1'b0;
                    timeout_d = 1'b1;
                    code_d    = 16'hFFFF;
                end else if (hb_hit && !xfer) begin
                    state_d   = S_DONE;
                    pass_d    = 1'b0;
                    timeout_d = 1'b0;
                    code_d    = 16'hFFFE;
                end
            end
            S_DONE: begin
                if (restart) begin
                    state_d   = S_RESET;
                    cnt_d     = '0;
                    pass_d    = 1'b0;
                    timeout_d = 1'b0;
                    code_d    = 16'h0000;
                end
            end
            default: state_d = S_RESET;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_RESET;
            rst_cnt_q   <= '0;
            cnt_q       <= '0;
            pass_q      <= 1'b0;
            timeout_q   <= 1'b0;
            code_q      <= '0;
            soc_rst_n_q <= 1'b0;
            mb_ready_q  <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            rst_cnt_q   <= rst_cnt_d;
            cnt_q       <= cnt_d;
            pass_q      <= pass_d;
            timeout_q   <= timeout_d;
            code_q      <= code_d;
            soc_rst_n_q <= state_d != S_RESET;
            mb_ready_q  <= state_d == S_RUN;
            done_q      <= state_d == S_DONE;
        end
    end

    assign soc_rst_n = soc_rst_n_q;
    assign mb_ready  = mb_ready_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign timeout   = timeout_q;
    assign fail_code = code_q;
    assign cycle_cnt = cnt_q;
endmodule

// File: tb/tb_soc_run_ctrl.sv
// tb_soc_run_ctrl: two controllers (long and short timeout) driven by shared stimulus,
// each compared every cycle against an event-level reference model.
module tb_soc_run_ctrl;
    localparam int RST = 10;
    localparam int TO_A = 100000, TO_B = 20;
    localparam int HB_A = 4096, HB_B = 8;

    typedef struct {
        int          rst_left;
        bit          run, fin, pass, to;
        int          cyc, hb;
        logic [15:0] code;
    } m_t;

    logic        clk = 0, rst_n = 0, restart = 0, mb_valid = 0;
    logic [31:0] mb_data = 0;
    logic        o_rdy[2], o_srst[2], o_done[2], o_pass[2], o_to[2];
    logic [15:0] o_code[2];
    logic [31:0] o_cnt[2];
    m_t          m[2];
    int          n_vec = 0, n_bad = 0;
    int          to_max[2] = '{TO_A, TO_B};
    int          hb_max[2] = '{HB_A, HB_B};

    always #5 clk = ~clk;

    soc_run_ctrl #(.RST_CYCLES(RST), .TIMEOUT_CYCLES(TO_A), .HB_CYCLES(HB_A), .CNT_W(32)) u_a (
        .clk(clk), .rst_n(rst_n), .restart(restart), .mb_valid(mb_valid), .mb_data(mb_data),
        .mb_ready(o_rdy[0]), .soc_rst_n(o_srst[0]), .done(o_done[0]), .pass(o_pass[0]),
        .timeout(o_to[0]), .fail_code(o_code[0]), .cycle_cnt(o_cnt[0]));

    soc_run_ctrl #(.RST_CYCLES(RST), .TIMEOUT_CYCLES(TO_B), .HB_CYCLES(HB_B), .CNT_W(32)) u_b (
        .clk(clk), .rst_n(rst_n), .restart(restart), .mb_valid(mb_valid), .mb_data(mb_data),
        .mb_ready(o_rdy[1]), .soc_rst_n(o_srst[1]), .done(o_done[1]), .pass(o_pass[1]),
        .timeout(o_to[1]), .fail_code(o_code[1]), .cycle_cnt(o_cnt[1]));

    function automatic m_t m_reset();
        m_t s;
        s.rst_left = RST; s.run = 0; s.fin = 0; s.pass = 0; s.to = 0;
        s.cyc = 0; s.hb = 0; s.code = 16'h0;
        return s;
    endfunction

    // One rising edge of the reference: reset countdown, run bookkeeping, verdict rules.
    function automatic m_t m_edge(m_t s, int tmax, int hmax, bit v, logic [31:0] d, bit r);
        if (s.fin) return r ? m_reset() : s;
        if (s.rst_left > 0) begin
            s.rst_left--;
            s.run = (s.rst_left == 0);
            return s;
        end
        s.cyc = (s.cyc < tmax) ? s.cyc + 1 : tmax;
        s.hb++;
        if (v && d[31:16] == 16'hD0DE) begin
            s.fin = 1; s.run = 0; s.code = d[15:0]; s.pass = (d[15:0] == 0); s.to = 0;
        end else if (s.cyc == tmax) begin
            s.fin = 1; s.run = 0; s.code = 16'hFFFF; s.pass = 0; s.to = 1;
        end else if (v) begin
            s.hb = 0;
`ifdef SOC_RUN_CTRL_HEARTBEAT_EN
        end else if (s.hb == hmax) begin
            s.fin = 1; s.run = 0; s.code = 16'hFFFE; s.pass = 0; s.to = 0;
`endif
        end
        return s;
    endfunction

    function automatic logic [52:0] exp_of(m_t s);
        return {s.rst_left == 0, s.run, s.fin, s.pass, s.to, s.code, 32'(s.cyc)};
    endfunction

    function automatic logic [52:0] obs(int i);
        return {o_srst[i], o_rdy[i], o_done[i], o_pass[i], o_to[i], o_code[i], o_cnt[i]};
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_vec++;
        assert (got === want) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, got, want);
        end
    endtask

    task automatic step(input bit v, input logic [31:0] d, input bit r);
        mb_valid = v; mb_data = d; restart = r;
        @(posedge clk);
        for (int i = 0; i < 2; i++) m[i] = m_edge(m[i], to_max[i], hb_max[i], v, d, r);
        @(negedge clk);
        chk("model_a", 64'(obs(0)), 64'(exp_of(m[0])));
        chk("model_b", 64'(obs(1)), 64'(exp_of(m[1])));
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(0, 32'h0, 0);
    endtask

    // Reset asserted mid-cycle with a terminate word on the bus; the word must be lost.
    task automatic arst();
        mb_valid = 1; mb_data = 32'hD0DE_0003; restart = 0;
        #2 rst_n = 0;
        #1;
        chk("arst_a", 64'(obs(0)), 64'd0);
        chk("arst_b", 64'(obs(1)), 64'd0);
        for (int i = 0; i < 2; i++) m[i] = m_reset();
        @(negedge clk);
        rst_n = 1; mb_valid = 0;
    endtask

    initial begin
        bit          v, r;
        logic [31:0] d;
        int          w;
        for (int i = 0; i < 2; i++) m[i] = m_reset();
        @(negedge clk);
        chk("reset_a", 64'(obs(0)), 64'd0);
        chk("reset_b", 64'(obs(1)), 64'd0);
        rst_n = 1;
        for (int k = 1; k <= RST; k++) begin
            step(0, 32'h0, 0);
            chk("rst_seq_srst", 64'(o_srst[0]), 64'(k == RST));
            chk("rst_seq_rdy", 64'(o_rdy[0]), 64'(k == RST));
        end
        chk("run_cnt0", 64'(o_cnt[0]), 64'd0);

        idle(49);
        step(1, 32'hD0DE_0000, 0);
        chk("pass_done", 64'(o_done[0]), 64'd1);
        chk("pass_pass", 64'(o_pass[0]), 64'd1);
        chk("pass_code", 64'(o_code[0]), 64'd0);
        chk("pass_to", 64'(o_to[0]), 64'd0);
        chk("pass_rdy", 64'(o_rdy[0]), 64'd0);
        idle(3);
        chk("pass_cnt_hold", 64'(o_cnt[0]), 64'd50);
`ifndef SOC_RUN_CTRL_HEARTBEAT_EN
        chk("to_done", 64'(o_done[1]), 64'd1);
        chk("to_flag", 64'(o_to[1]), 64'd1);
        chk("to_code", 64'(o_code[1]), 64'hFFFF);
        chk("to_cnt", 64'(o_cnt[1]), 64'd20);
`endif

        step(0, 32'h0, 1);
        chk("restart_clear", 64'(obs(0)), 64'd0);
        for (int k = 1; k <= RST; k++) begin
            chk("restart_srst_low", 64'(o_srst[0]), 64'd0);
            step(0, 32'h0, 0);
        end
        step(1, 32'h1234_5678, 0);
        chk("progress_nodone", 64'(o_done[0]), 64'd0);
        step(1, 32'hD0DE_0007, 0);
        chk("fail_pass", 64'(o_pass[0]), 64'd0);
        chk("fail_code", 64'(o_code[0]), 64'd7);

        step(0, 32'h0, 1);
        idle(RST);
        idle(19);
        step(1, 32'hD0DE_0000, 0);
`ifndef SOC_RUN_CTRL_HEARTBEAT_EN
        chk("tie_pass", 64'(o_pass[1]), 64'd1);
        chk("tie_to", 64'(o_to[1]), 64'd0);
        chk("tie_cnt", 64'(o_cnt[1]), 64'd20);
`endif

`ifdef SOC_RUN_CTRL_HEARTBEAT_EN
        step(0, 32'h0, 1);
        idle(RST);
        for (int j = 0; j < 2; j++) begin
            idle(4);
            step(1, 32'h0000_1111, 0);
        end
        chk("hb_alive", 64'(o_done[1]), 64'd0);
        w = 0;
        while (!o_done[1] && w < 10) begin
            step(0, 32'h0, 0);
            w++;
        end
        chk("hb_done", 64'(o_done[1]), 64'd1);
        chk("hb_code", 64'(o_code[1]), 64'hFFFE);
        chk("hb_to", 64'(o_to[1]), 64'd0);
`endif

        step(0, 32'h0, 1);
        idle(RST + 3);
        arst();
        idle(RST + 2);

        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 299) == 0) arst();
            else begin
                v = ($urandom_range(0, 2) == 0);
                d = $urandom;
                if ($urandom_range(0, 7) == 0) d[31:16] = 16'hD0DE;
                if ($urandom_range(0, 1) == 0) d[15:0] = 16'h0;
                r = ($urandom_range(0, 9) == 0);
                step(v, d, r);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
